// File: rtl/uart_byte_rx.sv
// UART byte receiver: 8N1 frames, 16x oversampling, 3-sample majority vote at mid-bit.
// Emits a one-cycle rx_done with the byte, or a one-cycle frame_err on a bad stop bit.
`timescale 1ns/1ps
module uart_byte_rx #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       uart_rx,
  input  logic [2:0] baud_set,
  output logic [7:0] data_byte,
  output logic       rx_done,
  output logic       frame_err,
  output logic       uart_state
);

  localparam int unsigned DIV_0 = CLK_FREQ / (9600   * OVERSAMPLE) - 1;
  localparam int unsigned DIV_1 = CLK_FREQ / (19200  * OVERSAMPLE) - 1;
  localparam int unsigned DIV_2 = CLK_FREQ / (38400  * OVERSAMPLE) - 1;
  localparam int unsigned DIV_3 = CLK_FREQ / (57600  * OVERSAMPLE) - 1;
  localparam int unsigned DIV_4 = CLK_FREQ / (115200 * OVERSAMPLE) - 1;
  localparam int unsigned DIV_W = $clog2(DIV_0 + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q, state_d;
  logic             rx_s1, rx_s2, rx_s3;
  logic [2:0]       baud_q;
  logic [DIV_W-1:0] div_cnt, div_max_c;
  logic [3:0]       tick_cnt;
  logic [2:0]       bit_cnt;
  logic             samp7, samp8;
  logic [7:0]       shift_reg;
  logic             tick_c, mid_c, end_c, vote_c, start_edge_c, enter_start_c;
  logic             done_c, ferr_c;

  // Two-flop synchronizer plus a delayed copy for falling-edge detection
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  always_comb begin
    div_max_c = DIV_W'(DIV_0);
    case (baud_q)
      3'd1:    div_max_c = DIV_W'(DIV_1);
      3'd2:    div_max_c = DIV_W'(DIV_2);
      3'd3:    div_max_c = DIV_W'(DIV_3);
      3'd4:    div_max_c = DIV_W'(DIV_4);
      default: div_max_c = DIV_W'(DIV_0);
    endcase
  end

  assign start_edge_c  = rx_s3 & ~rx_s2;
  assign tick_c        = (state_q != IDLE) && (div_cnt == div_max_c);
  assign mid_c         = tick_c && (tick_cnt == 4'd9);
  assign end_c         = tick_c && (tick_cnt == 4'd15);
  assign vote_c        = (samp7 & samp8) | (samp7 & rx_s2) | (samp8 & rx_s2);
  assign enter_start_c = (state_q == IDLE) && start_edge_c;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state and strobe decisions
  always_comb begin
    state_d = state_q;
    done_c  = 1'b0;
    ferr_c  = 1'b0;
    case (state_q)
      IDLE:  if (start_edge_c) state_d = START;
      START: begin
        if (mid_c && vote_c) state_d = IDLE;
        else if (end_c)      state_d = DATA;
      end
      DATA:  if (end_c && (bit_cnt == 3'd7)) state_d = STOP;
      STOP: begin
        if (mid_c) begin
          state_d = IDLE;
          done_c  = vote_c;
          ferr_c  = ~vote_c;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Baud latch, tick generation, vote sampling and data capture
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      baud_q    <= 3'd0;
      div_cnt   <= '0;
      tick_cnt  <= 4'd0;
      bit_cnt   <= 3'd0;
      samp7     <= 1'b1;
      samp8     <= 1'b1;
      shift_reg <= 8'h00;
    end else if (enter_start_c) begin
      baud_q   <= baud_set;
      div_cnt  <= '0;
      tick_cnt <= 4'd0;
      bit_cnt  <= 3'd0;
    end else if (state_q == IDLE) begin
      div_cnt <= '0;
    end else if (tick_c) begin
      div_cnt  <= '0;
      tick_cnt <= tick_cnt + 4'd1;
      if (tick_cnt == 4'd7) samp7 <= rx_s2;
      if (tick_cnt == 4'd8) samp8 <= rx_s2;
      if ((state_q == DATA) && (tick_cnt == 4'd9))  shift_reg[bit_cnt] <= vote_c;
      if ((state_q == DATA) && (tick_cnt == 4'd15)) bit_cnt <= bit_cnt + 3'd1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      data_byte  <= 8'h00;
      rx_done    <= 1'b0;
      frame_err  <= 1'b0;
      uart_state <= 1'b0;
    end else begin
      rx_done    <= done_c;
      frame_err  <= ferr_c;
      uart_state <= (state_d != IDLE);
      if (done_c) data_byte <= shift_reg;
    end
  end

endmodule
